// File: rtl/l2_cache_pkg.sv
// Shared types for the L2 controller: FSM state encoding and a way-index to one-hot helper.
// Purely declarative; no timing or flow-control behaviour lives here.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FETCH     = 3'd3,
    ALLOC     = 3'd4
  } state_e;

  localparam int MAX_WAYS = 64;

  // Wide result; callers cast down to their own way count.
  function automatic logic [MAX_WAYS-1:0] onehot(input logic [31:0] idx, input logic [31:0] n);
    logic [MAX_WAYS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      r[i] = (32'(i) == idx) && (32'(i) < n);
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_victim_sel.sv
// Victim picker: lowest-index invalid way, else the LRU way; purely combinational.
// Zero latency, no flow control.
module l2_victim_sel #(
  parameter int S_ASSOC = 8,
  parameter int S_WIDTH = $clog2(S_ASSOC)
) (
  input  logic [S_ASSOC-1:0] valid_vec_i,
  input  logic [S_WIDTH-1:0] lru_i,
  output logic [S_WIDTH-1:0] victim_o
);

  // Descending scan so the lowest invalid index is the last one written.
  always_comb begin
    victim_o = lru_i;
    for (int i = S_ASSOC - 1; i >= 0; i--) begin
      if (!valid_vec_i[i]) victim_o = S_WIDTH'(i);
    end
  end

endmodule

// File: rtl/l2_cache_ctrl_gen.sv
// L2 controller FSM: hit responds 2 cycles after request; misses write back/fetch/allocate.
// Upstream request is held until mem_resp; pmem requests are held until pmem_resp.
module l2_cache_ctrl_gen
  import l2_cache_pkg::*;
#(
  parameter int S_ASSOC         = 8,
  parameter int S_WIDTH         = $clog2(S_ASSOC),
  parameter bit FULL_LINE_WRITE = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               pmem_resp,
  input  logic               hit,
  input  logic [S_ASSOC-1:0] tag_hit,
  input  logic [S_ASSOC-1:0] valid_vec,
  input  logic [S_ASSOC-1:0] dirty_vec,
  input  logic [S_WIDTH-1:0] lru_out,
  input  logic               ctr_clear,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               pmem_addr_sel,
  output logic               mem_resp,
  output logic               read_data,
  output logic [S_ASSOC-1:0] load_data,
  output logic [S_ASSOC-1:0] load_tag,
  output logic [S_ASSOC-1:0] set_valid,
  output logic [S_ASSOC-1:0] set_dirty,
  output logic [S_ASSOC-1:0] clear_dirty,
  output logic               load_lru,
  output logic [S_WIDTH-1:0] victim_way,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count,
  output logic [CNT_W-1:0]   wb_count
);

  typedef logic [S_ASSOC-1:0] way_vec_t;

  state_e             state_q, state_d;
  logic [S_WIDTH-1:0] victim_q, victim_d;
  logic               relookup_q, relookup_d;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic               hit_inc, miss_inc, wb_inc;

  logic               req, is_write, victim_dirty;
  logic [S_WIDTH-1:0] victim_sel;
  way_vec_t           victim_oh;
  state_e             fill_state;

  assign req      = mem_read | mem_write;
  assign is_write = mem_write & ~mem_read;

  l2_victim_sel #(
    .S_ASSOC (S_ASSOC),
    .S_WIDTH (S_WIDTH)
  ) u_victim_sel (
    .valid_vec_i (valid_vec),
    .lru_i       (lru_out),
    .victim_o    (victim_sel)
  );

  assign victim_dirty = valid_vec[victim_sel] & dirty_vec[victim_sel];
  assign victim_oh    = way_vec_t'(onehot(32'(victim_q), 32'(S_ASSOC)));
  // Reads and merge-writes need the old line from memory; full-line writes skip the fetch.
  assign fill_state   = (!is_write || !FULL_LINE_WRITE) ? FETCH : ALLOC;

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    relookup_d    = relookup_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    mem_resp      = 1'b0;
    read_data     = 1'b0;
    load_data     = '0;
    load_tag      = '0;
    set_valid     = '0;
    set_dirty     = '0;
    clear_dirty   = '0;
    load_lru      = 1'b0;
    case (state_q)
      IDLE: begin
        read_data = req;
        if (req) state_d = LOOKUP;
      end
      LOOKUP: begin
        relookup_d = 1'b0;
        if (hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          hit_inc  = ~relookup_q;
          if (is_write) begin
            load_data = tag_hit;
            set_dirty = tag_hit;
          end
          state_d = IDLE;
        end else begin
          miss_inc = ~relookup_q;
          victim_d = victim_sel;
          state_d  = victim_dirty ? WRITEBACK : fill_state;
        end
      end
      WRITEBACK: begin
        pmem_addr_sel = 1'b1;
        pmem_write    = ~pmem_resp;
        if (pmem_resp) begin
          clear_dirty = victim_oh;
          wb_inc      = 1'b1;
          state_d     = fill_state;
        end
      end
      FETCH: begin
        pmem_read = ~pmem_resp;
        if (pmem_resp) begin
          load_data = victim_oh;
          load_tag  = victim_oh;
          set_valid = victim_oh;
          // A write re-enters LOOKUP so the now-resident line takes the merge on a hit.
          if (is_write) begin
            relookup_d = 1'b1;
            state_d    = LOOKUP;
          end else begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      ALLOC: begin
        load_data = victim_oh;
        load_tag  = victim_oh;
        set_valid = victim_oh;
        set_dirty = victim_oh;
        load_lru  = 1'b1;
        mem_resp  = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d    = IDLE;
        relookup_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      victim_q   <= '0;
      relookup_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      relookup_q <= relookup_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ctr_clear) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_inc && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (wb_inc && wb_cnt_q != '1)     wb_cnt_q   <= wb_cnt_q + CNT_W'(1);
    end
  end

  assign victim_way = victim_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_l2_cache_ctrl_gen.sv
// Directed bench: dut_a is full-line-write with 32-bit counters, dut_b is fetch-then-merge with 2-bit counters.
module tb_l2_cache_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst, ctr_clear;
  logic [7:0] valid_vec, dirty_vec;
  logic [2:0] lru_out;

  logic       mem_read, mem_write, pmem_resp, hit;
  logic [7:0] tag_hit;
  logic       a_pmem_read, a_pmem_write, a_pmem_addr_sel, a_mem_resp, a_read_data, a_load_lru;
  logic [7:0] a_load_data, a_load_tag, a_set_valid, a_set_dirty, a_clear_dirty;
  logic [2:0] a_victim_way;
  logic [31:0] a_hit_count, a_miss_count, a_wb_count;

  logic       b_mem_read, b_mem_write, b_pmem_resp, b_hit;
  logic [7:0] b_tag_hit;
  logic       b_pmem_read, b_pmem_write, b_pmem_addr_sel, b_mem_resp, b_read_data, b_load_lru;
  logic [7:0] b_load_data, b_load_tag, b_set_valid, b_set_dirty, b_clear_dirty;
  logic [2:0] b_victim_way;
  logic [1:0] b_hit_count, b_miss_count, b_wb_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_cache_ctrl_gen #(.S_ASSOC(8), .FULL_LINE_WRITE(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .pmem_resp(pmem_resp),
    .hit(hit), .tag_hit(tag_hit), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_out(lru_out),
    .ctr_clear(ctr_clear), .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
    .pmem_addr_sel(a_pmem_addr_sel), .mem_resp(a_mem_resp), .read_data(a_read_data),
    .load_data(a_load_data), .load_tag(a_load_tag), .set_valid(a_set_valid),
    .set_dirty(a_set_dirty), .clear_dirty(a_clear_dirty), .load_lru(a_load_lru),
    .victim_way(a_victim_way), .hit_count(a_hit_count), .miss_count(a_miss_count),
    .wb_count(a_wb_count)
  );

  l2_cache_ctrl_gen #(.S_ASSOC(8), .FULL_LINE_WRITE(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_mem_read), .mem_write(b_mem_write), .pmem_resp(b_pmem_resp),
    .hit(b_hit), .tag_hit(b_tag_hit), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_out(lru_out),
    .ctr_clear(ctr_clear), .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_addr_sel(b_pmem_addr_sel), .mem_resp(b_mem_resp), .read_data(b_read_data),
    .load_data(b_load_data), .load_tag(b_load_tag), .set_valid(b_set_valid),
    .set_dirty(b_set_dirty), .clear_dirty(b_clear_dirty), .load_lru(b_load_lru),
    .victim_way(b_victim_way), .hit_count(b_hit_count), .miss_count(b_miss_count),
    .wb_count(b_wb_count)
  );

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ctr_clear = 1'b0; valid_vec = 8'hFF; dirty_vec = 8'h00; lru_out = 3'd0;
    mem_read = 0; mem_write = 0; pmem_resp = 0; hit = 0; tag_hit = 8'h00;
    b_mem_read = 0; b_mem_write = 0; b_pmem_resp = 0; b_hit = 0; b_tag_hit = 8'h00;
    repeat (2) nedge();
    rst = 1'b0; #1;
    checks++; if ({a_pmem_read, a_pmem_write, a_pmem_addr_sel, a_mem_resp, a_read_data, a_load_lru} !== 6'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 000000", {a_pmem_read, a_pmem_write, a_pmem_addr_sel, a_mem_resp, a_read_data, a_load_lru}); end
    checks++; if ({a_load_data, a_load_tag, a_set_valid, a_set_dirty, a_clear_dirty} !== 40'h0) begin errors++; $display("FAIL rst_ways: got %h want 0", {a_load_data, a_load_tag, a_set_valid, a_set_dirty, a_clear_dirty}); end
    checks++; if (a_victim_way !== 3'd0) begin errors++; $display("FAIL rst_victim: got %0d want 0", a_victim_way); end
    checks++; if ({a_hit_count, a_miss_count, a_wb_count} !== 96'h0) begin errors++; $display("FAIL rst_cnt_a: got %0d/%0d/%0d want 0/0/0", a_hit_count, a_miss_count, a_wb_count); end
    checks++; if ({b_hit_count, b_miss_count, b_wb_count} !== 6'h0) begin errors++; $display("FAIL rst_cnt_b: got %0d/%0d/%0d want 0/0/0", b_hit_count, b_miss_count, b_wb_count); end
  endtask

  // Two-cycle hit on dut_a; rd/wr select the request, exp_ld is the expected write enable.
  task automatic run_hit(input logic rd, input logic wr, input logic [7:0] th, input logic [7:0] exp_ld, input logic [31:0] exp_hits, input string nm);
    nedge(); mem_read = rd; mem_write = wr; hit = 1'b1; tag_hit = th; #1;
    checks++; if (a_read_data !== 1'b1 || a_mem_resp !== 1'b0) begin errors++; $display("FAIL %s_idle: rd_en=%b resp=%b want 1/0", nm, a_read_data, a_mem_resp); end
    nedge(); #1;
    checks++; if (a_mem_resp !== 1'b1 || a_load_lru !== 1'b1) begin errors++; $display("FAIL %s_resp: resp=%b lru=%b want 1/1", nm, a_mem_resp, a_load_lru); end
    checks++; if (a_load_data !== exp_ld || a_set_dirty !== exp_ld) begin errors++; $display("FAIL %s_wr: ld=%h sd=%h want %h", nm, a_load_data, a_set_dirty, exp_ld); end
    checks++; if (a_pmem_read !== 1'b0 || a_pmem_write !== 1'b0) begin errors++; $display("FAIL %s_pmem: rd=%b wr=%b want 0/0", nm, a_pmem_read, a_pmem_write); end
    nedge(); mem_read = 0; mem_write = 0; hit = 0; tag_hit = 8'h00; #1;
    checks++; if (a_hit_count !== exp_hits || a_mem_resp !== 1'b0) begin errors++; $display("FAIL %s_cnt: hits=%0d resp=%b want %0d/0", nm, a_hit_count, a_mem_resp, exp_hits); end
  endtask

  task automatic test_read_hit();
    run_hit(1'b1, 1'b0, 8'h04, 8'h00, 32'd1, "read_hit");
  endtask

  task automatic test_write_hit();
    run_hit(1'b0, 1'b1, 8'h02, 8'h02, 32'd2, "write_hit");
  endtask

  task automatic test_priority();
    run_hit(1'b1, 1'b1, 8'h01, 8'h00, 32'd3, "prio");
  endtask

  task automatic test_read_miss_fetch();
    nedge(); mem_read = 1; valid_vec = 8'hF7; dirty_vec = 8'h00; lru_out = 3'd5; #1;
    nedge(); #1;
    checks++; if (a_pmem_read !== 1'b0 || a_mem_resp !== 1'b0) begin errors++; $display("FAIL rm_lookup: prd=%b resp=%b want 0/0", a_pmem_read, a_mem_resp); end
    for (int i = 0; i < 5; i++) begin
      nedge(); pmem_resp = 0; #1;
      checks++; if (a_pmem_read !== 1'b1 || a_victim_way !== 3'd3) begin errors++; $display("FAIL rm_fetch%0d: prd=%b victim=%0d want 1/3", i, a_pmem_read, a_victim_way); end
    end
    nedge(); pmem_resp = 1; #1;
    checks++; if (a_pmem_read !== 1'b0 || a_mem_resp !== 1'b1 || a_load_lru !== 1'b1) begin errors++; $display("FAIL rm_resp: prd=%b resp=%b lru=%b want 0/1/1", a_pmem_read, a_mem_resp, a_load_lru); end
    checks++; if (a_load_tag !== 8'h08 || a_set_valid !== 8'h08 || a_load_data !== 8'h08) begin errors++; $display("FAIL rm_fill: tag=%h val=%h data=%h want 08", a_load_tag, a_set_valid, a_load_data); end
    nedge(); mem_read = 0; pmem_resp = 0; valid_vec = 8'hFF; #1;
    checks++; if (a_miss_count !== 32'd1 || a_mem_resp !== 1'b0 || a_hit_count !== 32'd3) begin errors++; $display("FAIL rm_cnt: miss=%0d hit=%0d resp=%b want 1/3/0", a_miss_count, a_hit_count, a_mem_resp); end
  endtask

  task automatic test_writeback();
    nedge(); mem_read = 1; valid_vec = 8'hFF; dirty_vec = 8'hFF; lru_out = 3'd6; #1;
    nedge(); #1;
    checks++; if (a_pmem_write !== 1'b0) begin errors++; $display("FAIL wb_lookup: pwr=%b want 0", a_pmem_write); end
    for (int i = 0; i < 2; i++) begin
      nedge(); pmem_resp = 0; #1;
      checks++; if (a_pmem_write !== 1'b1 || a_pmem_addr_sel !== 1'b1 || a_pmem_read !== 1'b0 || a_clear_dirty !== 8'h00) begin errors++; $display("FAIL wb_hold%0d: pwr=%b sel=%b prd=%b cd=%h want 1/1/0/00", i, a_pmem_write, a_pmem_addr_sel, a_pmem_read, a_clear_dirty); end
    end
    checks++; if (a_victim_way !== 3'd6) begin errors++; $display("FAIL wb_victim: got %0d want 6", a_victim_way); end
    nedge(); pmem_resp = 1; #1;
    checks++; if (a_pmem_write !== 1'b0 || a_clear_dirty !== 8'h40 || a_wb_count !== 32'd0) begin errors++; $display("FAIL wb_done: pwr=%b cd=%h wb=%0d want 0/40/0", a_pmem_write, a_clear_dirty, a_wb_count); end
    nedge(); pmem_resp = 0; #1;
    checks++; if (a_pmem_read !== 1'b1 || a_pmem_write !== 1'b0 || a_pmem_addr_sel !== 1'b0 || a_wb_count !== 32'd1) begin errors++; $display("FAIL wb_fetch: prd=%b pwr=%b sel=%b wb=%0d want 1/0/0/1", a_pmem_read, a_pmem_write, a_pmem_addr_sel, a_wb_count); end
    nedge(); pmem_resp = 1; #1;
    checks++; if (a_mem_resp !== 1'b1 || a_load_tag !== 8'h40) begin errors++; $display("FAIL wb_resp: resp=%b tag=%h want 1/40", a_mem_resp, a_load_tag); end
    nedge(); mem_read = 0; pmem_resp = 0; dirty_vec = 8'h00; #1;
    checks++; if (a_miss_count !== 32'd2 || a_wb_count !== 32'd1) begin errors++; $display("FAIL wb_cnt: miss=%0d wb=%0d want 2/1", a_miss_count, a_wb_count); end
  endtask

  task automatic test_write_alloc();
    nedge(); mem_write = 1; valid_vec = 8'hFF; dirty_vec = 8'h00; lru_out = 3'd2; #1;
    nedge(); #1;
    checks++; if (a_mem_resp !== 1'b0) begin errors++; $display("FAIL al_lookup: resp=%b want 0", a_mem_resp); end
    nedge(); #1;
    checks++; if (a_set_dirty !== 8'h04 || a_set_valid !== 8'h04 || a_load_tag !== 8'h04 || a_load_data !== 8'h04) begin errors++; $display("FAIL al_ways: sd=%h sv=%h tag=%h data=%h want 04", a_set_dirty, a_set_valid, a_load_tag, a_load_data); end
    checks++; if (a_mem_resp !== 1'b1 || a_load_lru !== 1'b1 || a_pmem_read !== 1'b0) begin errors++; $display("FAIL al_ctrl: resp=%b lru=%b prd=%b want 1/1/0", a_mem_resp, a_load_lru, a_pmem_read); end
    nedge(); mem_write = 0; #1;
    checks++; if (a_miss_count !== 32'd3 || a_mem_resp !== 1'b0 || a_pmem_read !== 1'b0) begin errors++; $display("FAIL al_after: miss=%0d resp=%b prd=%b want 3/0/0", a_miss_count, a_mem_resp, a_pmem_read); end
  endtask

  task automatic test_fetch_merge();
    nedge(); b_mem_write = 1; valid_vec = 8'hFF; dirty_vec = 8'h00; lru_out = 3'd5; #1;
    checks++; if (b_read_data !== 1'b1) begin errors++; $display("FAIL fm_idle: rd_en=%b want 1", b_read_data); end
    nedge(); #1;
    nedge(); b_pmem_resp = 0; #1;
    checks++; if (b_pmem_read !== 1'b1 || b_set_dirty !== 8'h00 || b_mem_resp !== 1'b0) begin errors++; $display("FAIL fm_fetch: prd=%b sd=%h resp=%b want 1/00/0", b_pmem_read, b_set_dirty, b_mem_resp); end
    nedge(); b_pmem_resp = 1; #1;
    checks++; if (b_load_tag !== 8'h20 || b_set_valid !== 8'h20 || b_mem_resp !== 1'b0 || b_pmem_read !== 1'b0) begin errors++; $display("FAIL fm_fill: tag=%h sv=%h resp=%b prd=%b want 20/20/0/0", b_load_tag, b_set_valid, b_mem_resp, b_pmem_read); end
    nedge(); b_pmem_resp = 0; b_hit = 1; b_tag_hit = 8'h20; #1;
    checks++; if (b_mem_resp !== 1'b1 || b_set_dirty !== 8'h20 || b_load_data !== 8'h20) begin errors++; $display("FAIL fm_merge: resp=%b sd=%h ld=%h want 1/20/20", b_mem_resp, b_set_dirty, b_load_data); end
    nedge(); b_mem_write = 0; b_hit = 0; b_tag_hit = 8'h00; #1;
    checks++; if (b_hit_count !== 2'd0 || b_miss_count !== 2'd1 || b_mem_resp !== 1'b0) begin errors++; $display("FAIL fm_cnt: hit=%0d miss=%0d resp=%b want 0/1/0", b_hit_count, b_miss_count, b_mem_resp); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      nedge(); b_mem_read = 1; b_hit = 1; b_tag_hit = 8'h01; #1;
      nedge(); #1;
      nedge(); b_mem_read = 0; b_hit = 0; b_tag_hit = 8'h00; #1;
      exp_v = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if (b_hit_count !== exp_v) begin errors++; $display("FAIL sat_%0d: hits=%0d want %0d", i, b_hit_count, exp_v); end
    end
    nedge(); b_mem_read = 1; b_hit = 1; b_tag_hit = 8'h01; #1;
    nedge(); ctr_clear = 1; #1;
    checks++; if (b_mem_resp !== 1'b1) begin errors++; $display("FAIL clr_resp: resp=%b want 1", b_mem_resp); end
    nedge(); ctr_clear = 0; b_mem_read = 0; b_hit = 0; b_tag_hit = 8'h00; #1;
    checks++; if (b_hit_count !== 2'd0 || b_miss_count !== 2'd0) begin errors++; $display("FAIL clr_b: hit=%0d miss=%0d want 0/0", b_hit_count, b_miss_count); end
    checks++; if (a_hit_count !== 32'd0 || a_miss_count !== 32'd0 || a_wb_count !== 32'd0) begin errors++; $display("FAIL clr_a: %0d/%0d/%0d want 0/0/0", a_hit_count, a_miss_count, a_wb_count); end
  endtask

  task automatic test_reset_mid();
    nedge(); mem_read = 1; valid_vec = 8'hFF; dirty_vec = 8'h00; lru_out = 3'd1; #1;
    nedge(); #1;
    nedge(); pmem_resp = 0; #1;
    checks++; if (a_pmem_read !== 1'b1 || a_miss_count !== 32'd1 || a_victim_way !== 3'd1) begin errors++; $display("FAIL rm_pre: prd=%b miss=%0d victim=%0d want 1/1/1", a_pmem_read, a_miss_count, a_victim_way); end
    rst = 1;
    nedge(); mem_read = 0; #1;
    checks++; if (a_pmem_read !== 1'b0 || a_pmem_write !== 1'b0 || a_mem_resp !== 1'b0) begin errors++; $display("FAIL rmid_drop: prd=%b pwr=%b resp=%b want 0/0/0", a_pmem_read, a_pmem_write, a_mem_resp); end
    checks++; if (a_miss_count !== 32'd0 || a_victim_way !== 3'd0) begin errors++; $display("FAIL rmid_state: miss=%0d victim=%0d want 0/0", a_miss_count, a_victim_way); end
    nedge(); rst = 0; pmem_resp = 1; #1;
    checks++; if (a_mem_resp !== 1'b0 || a_pmem_read !== 1'b0 || a_read_data !== 1'b0) begin errors++; $display("FAIL rmid_idle: resp=%b prd=%b rd_en=%b want 0/0/0", a_mem_resp, a_pmem_read, a_read_data); end
    nedge(); pmem_resp = 0; #1;
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_priority();
    test_read_miss_fetch();
    test_writeback();
    test_write_alloc();
    test_fetch_merge();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
